// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data SRAM between the core M-stage port and the
// host port. Fixed Idle/Cmd/Resp sequence with RV32 store lane steering and load extension.
module core_mem_arbiter #(
  parameter int unsigned MEM_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  // core port
  input  logic                      i_core_req,
  input  logic                      i_core_we,
  input  logic [2:0]                i_core_funct3,
  input  logic [31:0]               i_core_addr,
  input  logic [31:0]               i_core_wdata,
  output logic [31:0]               o_core_rdata,
  output logic                      o_core_stall,
  output logic                      o_core_err,
  // host port
  input  logic                      i_host_req,
  input  logic                      i_host_we,
  input  logic [31:0]               i_host_addr,
  input  logic [31:0]               i_host_wdata,
  output logic [31:0]               o_host_rdata,
  output logic                      o_host_ack,
  // SRAM port
  output logic                      o_mem_en,
  output logic [3:0]                o_mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]               o_mem_wdata,
  input  logic [31:0]               i_mem_rdata
);

  localparam int unsigned AddrLsbW = MEM_ADDR_WIDTH + 2;

  localparam logic OwnerCore = 1'b0;
  localparam logic OwnerHost = 1'b1;

  typedef enum logic [1:0] {StIdle, StCmd, StResp} state_e;

  state_e                state_q, state_d;
  // Holds the previous grant; during Cmd/Resp it is also the owner of the running access.
  logic                  last_owner_q, last_owner_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [AddrLsbW-1:0]   addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  grant_valid;
  logic                  grant_host;
  logic [1:0]            lane;
  logic                  misaligned;
  logic [3:0]            st_mask;
  logic [31:0]           st_wdata;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_data;

  logic                  unused_addr_bits;
  assign unused_addr_bits = ^{i_core_addr[31:AddrLsbW], i_host_addr[31:AddrLsbW],
                              i_host_addr[1:0]};

  // Arbitration: on a tie the requester that did not win last time is granted.
  always_comb begin
    grant_valid = i_core_req | i_host_req;
    if (i_core_req && i_host_req) begin
      grant_host = (last_owner_q == OwnerCore);
    end else begin
      grant_host = i_host_req;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_valid) state_d = StCmd;
      StCmd:   state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Payload capture at the grant edge
  always_comb begin
    last_owner_d = last_owner_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if (state_q == StIdle && grant_valid) begin
      last_owner_d = grant_host;
      if (grant_host) begin
        we_d     = i_host_we;
        funct3_d = 3'b010;
        addr_d   = {i_host_addr[AddrLsbW-1:2], 2'b00};
        wdata_d  = i_host_wdata;
      end else begin
        we_d     = i_core_we;
        funct3_d = i_core_funct3;
        addr_d   = i_core_addr[AddrLsbW-1:0];
        wdata_d  = i_core_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_q <= OwnerHost;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
    end else begin
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign lane = addr_q[1:0];

  always_comb begin
    misaligned = 1'b0;
    if (last_owner_q == OwnerCore) begin
      case (funct3_q)
        3'b001, 3'b101: misaligned = addr_q[0];
        3'b010:         misaligned = |addr_q[1:0];
        default:        misaligned = 1'b0;
      endcase
    end
  end

  // Store lane steering: data replicated across lanes, mask selects the bytes written.
  always_comb begin
    st_mask  = 4'b0000;
    st_wdata = wdata_q;
    if (last_owner_q == OwnerHost) begin
      st_mask = 4'b1111;
    end else begin
      case (funct3_q)
        3'b000: begin
          st_mask  = 4'b0001 << lane;
          st_wdata = {4{wdata_q[7:0]}};
        end
        3'b001: begin
          st_mask  = 4'b0011 << lane;
          st_wdata = {2{wdata_q[15:0]}};
        end
        3'b010:  st_mask = 4'b1111;
        default: st_mask = 4'b0000;
      endcase
    end
  end

  // Load formatting
  always_comb begin
    case (lane)
      2'd0:    ld_byte = i_mem_rdata[7:0];
      2'd1:    ld_byte = i_mem_rdata[15:8];
      2'd2:    ld_byte = i_mem_rdata[23:16];
      default: ld_byte = i_mem_rdata[31:24];
    endcase
    ld_half = lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = i_mem_rdata;
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = 32'h0;
    endcase
  end

  // Output logic
  always_comb begin
    o_mem_en     = 1'b0;
    o_mem_we     = 4'b0000;
    o_mem_addr   = '0;
    o_mem_wdata  = 32'h0;
    o_core_rdata = 32'h0;
    o_core_err   = 1'b0;
    o_host_rdata = 32'h0;
    o_host_ack   = 1'b0;
    unique case (state_q)
      StCmd: begin
        o_mem_en    = ~misaligned;
        o_mem_we    = (we_q && !misaligned) ? st_mask : 4'b0000;
        o_mem_addr  = addr_q[AddrLsbW-1:2];
        o_mem_wdata = st_wdata;
      end
      StResp: begin
        if (last_owner_q == OwnerHost) begin
          o_host_ack   = 1'b1;
          o_host_rdata = i_mem_rdata;
        end else begin
          o_core_err   = misaligned;
          o_core_rdata = misaligned ? 32'h0 : ld_data;
        end
      end
      default: ;
    endcase
  end

  // Combinational so the core stalls in the very cycle it raises a request.
  assign o_core_stall = i_core_req & ~(state_q == StResp && last_owner_q == OwnerCore);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Randomized bench for core_mem_arbiter: a behavioural SRAM plus a transaction-level reference
// model (word array, round-robin rule, lane/extension arithmetic) predicts every access.
module tb_core_mem_arbiter;

  localparam int unsigned Aw = 8;
  localparam int Core = 0;
  localparam int Host = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_core_req, i_core_we;
  logic [2:0]    i_core_funct3;
  logic [31:0]   i_core_addr, i_core_wdata;
  logic [31:0]   o_core_rdata;
  logic          o_core_stall, o_core_err;
  logic          i_host_req, i_host_we;
  logic [31:0]   i_host_addr, i_host_wdata;
  logic [31:0]   o_host_rdata;
  logic          o_host_ack;
  logic          o_mem_en;
  logic [3:0]    o_mem_we;
  logic [Aw-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [31:0]   i_mem_rdata;

  core_mem_arbiter #(.MEM_ADDR_WIDTH(Aw)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_core_req   (i_core_req),
    .i_core_we    (i_core_we),
    .i_core_funct3(i_core_funct3),
    .i_core_addr  (i_core_addr),
    .i_core_wdata (i_core_wdata),
    .o_core_rdata (o_core_rdata),
    .o_core_stall (o_core_stall),
    .o_core_err   (o_core_err),
    .i_host_req   (i_host_req),
    .i_host_we    (i_host_we),
    .i_host_addr  (i_host_addr),
    .i_host_wdata (i_host_wdata),
    .o_host_rdata (o_host_rdata),
    .o_host_ack   (o_host_ack),
    .o_mem_en     (o_mem_en),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] sram    [256];
  logic [31:0] ref_mem [256];

  // Behavioural SRAM macro; reloaded from the reference image while reset is low.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) sram[i] <= ref_mem[i];
      i_mem_rdata <= 32'h0;
    end else if (o_mem_en) begin
      i_mem_rdata <= sram[o_mem_addr];
      for (int b = 0; b < 4; b++) begin
        if (o_mem_we[b]) sram[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Pending requests and model state
  logic        c_pend, c_we, h_pend, h_we;
  logic [2:0]  c_f3;
  logic [31:0] c_addr, c_wdata, h_addr, h_wdata;
  int          last_owner;
  logic [2:0]  ld_ops [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    if ((f3 == 3'd1 || f3 == 3'd5) && lane[0]) return 1'b1;
    if (f3 == 3'd2 && lane != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_mask(input logic we, input logic [2:0] f3,
                                          input logic [1:0] lane, input logic mis);
    if (!we || mis) return 4'h0;
    case (f3)
      3'd0:    return 4'(1 << int'(lane));
      3'd1:    return 4'(3 << int'(lane));
      3'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return {24'h0, d[7:0]} * 32'h0101_0101;
      3'd1:    return {16'h0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> (8 * int'(lane));
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd2:    return word;
      3'd4:    return {24'h0, sh[7:0]};
      3'd5:    return {16'h0, sh[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive_inputs();
    i_core_req    = c_pend;
    i_core_we     = c_we;
    i_core_funct3 = c_f3;
    i_core_addr   = c_addr;
    i_core_wdata  = c_wdata;
    i_host_req    = h_pend;
    i_host_we     = h_we;
    i_host_addr   = h_addr;
    i_host_wdata  = h_wdata;
  endtask

  task automatic set_core(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
    c_pend = 1'b1; c_we = we; c_f3 = f3; c_addr = a; c_wdata = d;
  endtask

  task automatic set_host(input logic we, input logic [31:0] a, input logic [31:0] d);
    h_pend = 1'b1; h_we = we; h_addr = a; h_wdata = d;
  endtask

  task automatic rand_core();
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    we = 1'($urandom_range(0, 1));
    f3 = we ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 5)];
    a  = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      if (f3[1:0] == 2'd1) a[0] = 1'b0;
      if (f3 == 3'd2) a[1:0] = 2'b00;
    end
    set_core(we, f3, a, $urandom);
  endtask

  task automatic idle_cycle();
    c_pend = 1'b0; h_pend = 1'b0;
    drive_inputs();
    @(negedge clk);
    check_val("idle_en", 32'(o_mem_en), 32'h0);
    check_val("idle_stall", 32'(o_core_stall), 32'h0);
    check_val("idle_ack", 32'(o_host_ack), 32'h0);
    @(posedge clk); #1;
  endtask

  // One full access from an idle cycle; the expected winner follows the round-robin rule.
  task automatic run_access();
    int win;
    logic mis;
    logic [3:0] mask;
    logic [31:0] wd;
    logic [7:0] w;
    logic [1:0] lane;
    drive_inputs();
    if (c_pend && h_pend) win = (last_owner == Host) ? Core : Host;
    else win = c_pend ? Core : Host;
    @(negedge clk);
    check_val("idle_stall", 32'(o_core_stall), 32'(c_pend));
    check_val("idle_en", 32'(o_mem_en), 32'h0);
    check_val("idle_ack", 32'(o_host_ack), 32'h0);
    @(posedge clk); #1;
    last_owner = win;
    if (win == Core) begin
      w    = c_addr[9:2];
      lane = c_addr[1:0];
      mis  = exp_misaligned(c_f3, lane);
      mask = exp_mask(c_we, c_f3, lane, mis);
      wd   = exp_wdata(c_f3, c_wdata);
    end else begin
      w    = h_addr[9:2];
      lane = 2'd0;
      mis  = 1'b0;
      mask = h_we ? 4'hF : 4'h0;
      wd   = h_wdata;
    end
    @(negedge clk);
    check_val("cmd_en", 32'(o_mem_en), 32'(!mis));
    check_val("cmd_we", 32'(o_mem_we), 32'(mask));
    if (!mis) check_val("cmd_addr", 32'(o_mem_addr), 32'(w));
    if (mask != 4'h0) check_val("cmd_wdata", o_mem_wdata, wd);
    check_val("cmd_stall", 32'(o_core_stall), 32'(c_pend));
    check_val("cmd_ack", 32'(o_host_ack), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    if (win == Core) begin
      check_val("resp_stall", 32'(o_core_stall), 32'h0);
      check_val("resp_err", 32'(o_core_err), 32'(mis));
      if (mis) check_val("resp_rdata_mis", o_core_rdata, 32'h0);
      else if (!c_we) check_val("resp_rdata", o_core_rdata, exp_load(c_f3, lane, ref_mem[w]));
      check_val("resp_no_ack", 32'(o_host_ack), 32'h0);
      check_val("resp_hrdata0", o_host_rdata, 32'h0);
    end else begin
      check_val("resp_hstall", 32'(o_core_stall), 32'(c_pend));
      check_val("resp_ack", 32'(o_host_ack), 32'h1);
      if (!h_we) check_val("resp_hrdata", o_host_rdata, ref_mem[w]);
      check_val("resp_crdata0", o_core_rdata, 32'h0);
      check_val("resp_err0", 32'(o_core_err), 32'h0);
    end
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
    end
    if (win == Core) c_pend = 1'b0;
    else h_pend = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    rst = 1'b0;
    last_owner = Host;
    c_pend = 1'b0; h_pend = 1'b0;
    set_core(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF);
    set_host(1'b0, 32'h0000_0040, 32'h0);
    drive_inputs();

    // Reset state with both requests asserted
    @(negedge clk);
    check_val("rst_stall", 32'(o_core_stall), 32'h1);
    check_val("rst_en", 32'(o_mem_en), 32'h0);
    check_val("rst_we", 32'(o_mem_we), 32'h0);
    check_val("rst_addr", 32'(o_mem_addr), 32'h0);
    check_val("rst_wdata", o_mem_wdata, 32'h0);
    check_val("rst_ack", 32'(o_host_ack), 32'h0);
    check_val("rst_err", 32'(o_core_err), 32'h0);
    check_val("rst_crdata", o_core_rdata, 32'h0);
    check_val("rst_hrdata", o_host_rdata, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    run_access();  // core wins the first tie
    run_access();  // host served next

    // Halfword loads from 0x8001_7FFF
    set_host(1'b1, 32'h0000_0000, 32'h8001_7FFF); run_access();
    set_core(1'b0, 3'd1, 32'h0000_0000, 32'h0);    run_access();
    set_core(1'b0, 3'd1, 32'h0000_0002, 32'h0);    run_access();
    set_core(1'b0, 3'd5, 32'h0000_0002, 32'h0);    run_access();

    // Byte store to lane 3, then signed and unsigned byte loads
    set_core(1'b1, 3'd0, 32'h0000_0013, 32'h0000_00A5); run_access();
    set_core(1'b0, 3'd0, 32'h0000_0013, 32'h0);         run_access();
    set_core(1'b0, 3'd4, 32'h0000_0013, 32'h0);         run_access();

    // Misaligned accesses
    set_core(1'b0, 3'd2, 32'h0000_0006, 32'h0);         run_access();
    set_core(1'b1, 3'd2, 32'h0000_0006, 32'h1234_5678); run_access();
    set_core(1'b1, 3'd1, 32'h0000_0021, 32'hCAFE_F00D); run_access();

    // Reset during the Cmd cycle of a host write
    c_pend = 1'b0;
    set_host(1'b1, 32'h0000_0080, 32'h1234_5678);
    drive_inputs();
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("mid_cmd_en", 32'(o_mem_en), 32'h1);
    #1 rst = 1'b0;
    i_host_req = 1'b0;
    #1;
    check_val("mid_rst_en", 32'(o_mem_en), 32'h0);
    check_val("mid_rst_we", 32'(o_mem_we), 32'h0);
    check_val("mid_rst_ack", 32'(o_host_ack), 32'h0);
    last_owner = Host;
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycle();
    idle_cycle();
    set_host(1'b1, 32'h0000_0080, 32'h1234_5678); run_access();

    // Both requesting continuously: grants must alternate
    for (int i = 0; i < 20; i++) begin
      if (!c_pend) rand_core();
      if (!h_pend) set_host(1'($urandom_range(0, 1)), $urandom, $urandom);
      run_access();
    end
    c_pend = 1'b0; h_pend = 1'b0;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if (!c_pend && $urandom_range(0, 2) != 0) rand_core();
      if (!h_pend && $urandom_range(0, 2) == 0) set_host(1'($urandom_range(0, 1)), $urandom, $urandom);
      if (c_pend || h_pend) run_access();
      else idle_cycle();
    end
    while (c_pend || h_pend) run_access();

    for (int i = 0; i < 256; i++) check_val($sformatf("mem_%0d", i), sram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares the single-port data SRAM of Osiris I between the core's memory-stage port and an external host port (management/Wishbone bridge used for program load and debug). Performs round-robin arbitration, a fixed three-cycle access sequence, RV32 byte/halfword lane steering on stores, and sign/zero extension on loads. It sits between `core` and the data memory macro, and stalls the core while its access is pending.

## Interface

- MEM_ADDR_WIDTH, 8, SRAM word-address width (256 words)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- i_core_req  in  1  core access request; held with payload until stall drops
- i_core_we  in  1  1 = store, 0 = load
- i_core_funct3  in  3  RV32 load/store funct3
- i_core_addr  in  32  byte address
- i_core_wdata  in  32  store data, right-aligned
- o_core_rdata  out  32  formatted load data, valid in completion cycle only
- o_core_stall  out  1  core must hold its M stage
- o_core_err  out  1  misaligned access flag, completion cycle only
- i_host_req  in  1  host request; held with payload until ack
- i_host_we  in  1  host write
- i_host_addr  in  32  byte address; bits [1:0] ignored; always word access
- i_host_wdata  in  32  host write word
- o_host_rdata  out  32  raw read word, valid while ack = 1
- o_host_ack  out  1  one-cycle completion pulse
- o_mem_en  out  1  SRAM enable
- o_mem_we  out  4  per-byte write mask
- o_mem_addr  out  MEM_ADDR_WIDTH  word address = addr[MEM_ADDR_WIDTH+1:2]
- o_mem_wdata  out  32  lane-steered write data
- i_mem_rdata  in  32  SRAM read data, one-cycle latency after en

## Operation

- FSM: IDLE -> CMD -> RESP -> IDLE. Every access takes exactly three cycles. No pipelining.
- IDLE: if any request is present, latch the winner's payload and owner at the clock edge, then go to CMD.
- Arbitration: a `last_owner` register holds the previous grant.
  - On a tie, grant the requester that is not `last_owner`.
  - `last_owner` resets to HOST, so the core wins the first tie.
  - `last_owner` updates on entry to CMD.
- CMD: drive `o_mem_en`, `o_mem_addr`, `o_mem_we` and `o_mem_wdata` from the latched registers, then go to RESP.
- RESP: `i_mem_rdata` is valid.
  - Core owner: `o_core_stall` = 0, `o_core_rdata` = formatted data.
  - Host owner: `o_host_ack` = 1, `o_host_rdata` = `i_mem_rdata`.
  - Then go to IDLE.
- Store lane steering, with lane = latched addr[1:0]:
  - SB (000): byte replicated to all four lanes; mask = 0001 << lane.
  - SH (001): half replicated to both halves; mask = 0011 << lane.
  - SW (010): mask = 1111.
  - Host write: mask = 1111.
- Load formatting selects the byte/half at the lane:
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) passes through unchanged.
  - Other funct3 values return 0.
- Misalignment: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] ≠ 00.
  - The sequence still runs the full three cycles, but `o_mem_en` = 0 and `o_mem_we` = 0000 in CMD.
  - `o_core_err` = 1 and `o_core_rdata` = 0 in RESP.
- `o_core_stall` = `i_core_req` & !(state == RESP & owner == CORE). This is combinational and asserted in the request cycle itself.
- `o_core_rdata`, `o_host_rdata` and `o_core_err` drive 0 outside their completion cycle.
- A request arriving while busy waits in IDLE and is arbitrated against the other requester at that point.

## Timing

- Reset (rst = 0, asynchronous):
  - state = IDLE, `last_owner` = HOST.
  - All latched payload registers cleared.
  - `o_mem_en` = 0, `o_mem_we` = 0000, `o_mem_addr` = 0, `o_mem_wdata` = 0.
  - `o_host_ack` = 0, `o_core_err` = 0, both rdata outputs = 0.
  - `o_core_stall` follows `i_core_req`.
- Reset mid-access: the access is dropped and SRAM enables fall immediately. The requester gets no ack/completion and must re-request.
- Request sampled at edge t (state IDLE during cycle t):
  - CMD in cycle t+1.
  - RESP in cycle t+2.
  - IDLE in cycle t+3.
- Core stall is high in cycles t and t+1 and low in t+2.
- Minimum spacing between grant edges is 3 cycles.
- Back-to-back core requests are spaced 3 cycles apart (RESP -> IDLE -> new grant edge).

## Test plan

- Reset with both requests high -> after release, core granted first. Core SW addr 0x10, wdata 0xDEADBEEF -> CMD cycle: en = 1, we = 1111, addr = 4. Stall low exactly 2 cycles after the grant edge.
- SB addr 0x13 data 0x000000A5 -> we = 1000, wdata = 0xA5A5A5A5. Then LB addr 0x13 -> rdata 0xFFFFFFA5; LBU -> 0x000000A5.
- Memory word 0x8001_7FFF: LH addr 0x0 -> 0x00007FFF; LH addr 0x2 -> 0xFFFF8001; LHU addr 0x2 -> 0x00008001.
- Core and host both requesting continuously -> grants alternate CORE, HOST, CORE, ... Each `o_host_ack` is exactly one cycle; no starvation over 20 accesses.
- LW addr 0x6 -> en = 0 in CMD, `o_core_err` = 1 and rdata = 0 in RESP, memory contents unchanged.
- Host write issued, rst pulled low during CMD -> en and we drop asynchronously, no ack, state IDLE after release; reissued write completes normally.
